// File: rtl/pacman_pkg.sv
// pacman_pkg: shared directions, controller states and screen/sprite geometry for the Pac-Man draw path
package pacman_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 5;
    localparam int SPRITE_H = 5;
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - SPRITE_W);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - SPRITE_H);
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [2:0] {IDLE, ERASE_ARM, ERASE_RUN, DRAW_ARM, DRAW_RUN, ACK} ctrl_state_t;
endpackage

// File: rtl/draw_pass_handshake.sv
// draw_pass_handshake: one drawer pass -- hides the stale done flag in the ARM cycle and runs the watchdog
module draw_pass_handshake #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic arm,
    input  logic run,
    input  logic done_print,
    output logic pass_done,
    output logic pass_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    // cycles spent in the current pass; the ARM cycle counts as the first one
    always_ff @(posedge clock)
        if (reset) cnt <= '0;
        else cnt <= arm ? CNT_W'(1) : run ? cnt + 1'b1 : '0;
    assign pass_done = run && done_print;
    assign pass_timeout = run && !done_print && cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/pacman_draw_ctrl.sv
// pacman_draw_ctrl: erase-then-draw sequencer for the Pac-Man sprite drawers (erase pass built only with PACMAN_ERASE_EN)
module pacman_draw_ctrl
    import pacman_pkg::*;
#(
    parameter logic [7:0] START_X = 8'd78,
    parameter logic [6:0] START_Y = 7'd58,
    parameter int TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_req,
    input  logic [1:0] move_dir,
    input  logic [7:0] move_x,
    input  logic [6:0] move_y,
    input  logic       done_print,
    output logic       draw_en,
    output logic [7:0] draw_x,
    output logic [6:0] draw_y,
    output logic [1:0] dir_sel,
    output logic       erase,
    output logic       busy,
    output logic       move_ack,
    output logic       err_timeout
);
`ifdef PACMAN_ERASE_EN
    localparam ctrl_state_t FIRST_ARM = ERASE_ARM;
`else
    localparam ctrl_state_t FIRST_ARM = DRAW_ARM;
`endif
    ctrl_state_t state, state_n;
    logic pend, accept, same, arm, run, commit, en_n, old_n;
    logic pass_done, pass_timeout;
    logic [7:0] cur_x, new_x, clamp_x;
    logic [6:0] cur_y, new_y, clamp_y;
    logic [1:0] cur_dir, new_dir;

    assign clamp_x = move_x > X_MAX ? X_MAX : move_x;
    assign clamp_y = move_y > Y_MAX ? Y_MAX : move_y;
    assign accept = state == IDLE && !pend && move_req;
    assign same = new_x == cur_x && new_y == cur_y && new_dir == cur_dir;
    assign arm = state == ERASE_ARM || state == DRAW_ARM;
    assign run = state == ERASE_RUN || state == DRAW_RUN;
    assign commit = state == DRAW_RUN && pass_done;

    draw_pass_handshake #(.TIMEOUT(TIMEOUT)) u_pass (
        .clock(clock),
        .reset(reset),
        .arm(arm),
        .run(run),
        .done_print(done_print),
        .pass_done(pass_done),
        .pass_timeout(pass_timeout)
    );

    // next state; IDLE spends one cycle with the latched target before deciding
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = !pend ? IDLE : same ? ACK : FIRST_ARM;
`ifdef PACMAN_ERASE_EN
            ERASE_ARM: state_n = ERASE_RUN;
            ERASE_RUN: state_n = pass_done ? DRAW_ARM : pass_timeout ? IDLE : ERASE_RUN;
`endif
            DRAW_ARM:  state_n = DRAW_RUN;
            DRAW_RUN:  state_n = pass_done ? ACK : pass_timeout ? IDLE : DRAW_RUN;
            ACK:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        en_n = state_n inside {ERASE_ARM, ERASE_RUN, DRAW_ARM, DRAW_RUN};
        old_n = state_n inside {IDLE, ERASE_ARM, ERASE_RUN};
    end

    // state, target/current position and registered outputs aligned with the new state
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pend <= 1'b0;
            cur_x <= START_X;
            cur_y <= START_Y;
            cur_dir <= RIGHT;
            new_x <= START_X;
            new_y <= START_Y;
            new_dir <= RIGHT;
            draw_en <= 1'b0;
            draw_x <= START_X;
            draw_y <= START_Y;
            dir_sel <= RIGHT;
            busy <= 1'b0;
            move_ack <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_n;
            pend <= accept;
            if (accept) {new_dir, new_x, new_y} <= {move_dir, clamp_x, clamp_y};
            if (commit) {cur_dir, cur_x, cur_y} <= {new_dir, new_x, new_y};
            draw_en <= en_n;
            draw_x <= old_n ? (commit ? new_x : cur_x) : new_x;
            draw_y <= old_n ? (commit ? new_y : cur_y) : new_y;
            dir_sel <= old_n ? (commit ? new_dir : cur_dir) : new_dir;
            busy <= state_n != IDLE || accept;
            move_ack <= state_n == ACK;
            err_timeout <= err_timeout || pass_timeout;
        end
    end

`ifdef PACMAN_ERASE_EN
    // erase flag follows the erase pass so the colour mux blanks the old sprite
    always_ff @(posedge clock)
        if (reset) erase <= 1'b0;
        else erase <= state_n inside {ERASE_ARM, ERASE_RUN};
`else
    assign erase = 1'b0;
`endif
endmodule

// File: tb/tb_pacman_draw_ctrl.sv
// tb_pacman_draw_ctrl: table, random and corner-case checks of pacman_draw_ctrl against a move-level model
module tb_pacman_draw_ctrl;
    localparam int PASS = 30;
`ifdef PACMAN_ERASE_EN
    localparam int NPASS = 2;
    localparam int GLITCH = 40;
`else
    localparam int NPASS = 1;
    localparam int GLITCH = 10;
`endif
    typedef logic [17:0] key_t;
    typedef struct {
        logic [1:0] d;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] ex;
        logic [6:0] ey;
        logic       es;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic move_req = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic [7:0] move_x = 8'd0;
    logic [6:0] move_y = 7'd0;
    logic done_print;
    logic draw_en, erase, busy, move_ack, err_timeout;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [1:0] dir_sel;

    int total = 0;
    int bad = 0;
    string tag = "reset";
    logic [1:0] md = 2'd3;
    logic [7:0] mx = 8'd78;
    logic [6:0] my = 7'd58;
    logic last_stale;
    logic hang = 1'b0;
    vec_t tbl[8];

    pacman_draw_ctrl dut (
        .clock(clock),
        .reset(reset),
        .move_req(move_req),
        .move_dir(move_dir),
        .move_x(move_x),
        .move_y(move_y),
        .done_print(done_print),
        .draw_en(draw_en),
        .draw_x(draw_x),
        .draw_y(draw_y),
        .dir_sel(dir_sel),
        .erase(erase),
        .busy(busy),
        .move_ack(move_ack),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // model drawer: a pass lasts PASS enabled edges; done holds until the next pass's first enabled edge
    int dcnt, nc;
    logic prev_en;
    key_t prev_key;
    always @(posedge clock) begin
        if (reset) begin
            dcnt <= 0;
            done_print <= 1'b0;
            prev_en <= 1'b0;
            prev_key <= '0;
        end else begin
            prev_en <= draw_en;
            prev_key <= {erase, dir_sel, draw_x, draw_y};
            if (draw_en) begin
                nc = (prev_en && prev_key == {erase, dir_sel, draw_x, draw_y}) ? dcnt + 1 : 1;
                dcnt <= nc;
                done_print <= !hang && nc >= PASS;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0d want %0d", tag, nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_en", 32'(draw_en), 0);
        check("rst_x", 32'(draw_x), 78);
        check("rst_y", 32'(draw_y), 58);
        check("rst_dir", 32'(dir_sel), 3);
        check("rst_erase", 32'(erase), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(move_ack), 0);
        check("rst_err", 32'(err_timeout), 0);
    endtask

    // issue one move from an IDLE negedge, observe every cycle until ack/abort, compare with the model
    task automatic do_check(input logic [1:0] d, input logic [7:0] x, input logic [6:0] y,
                            input logic [7:0] ex, input logic [6:0] ey, input logic es, input int glitch);
        int lat, en_cyc, np;
        key_t k0, k1, k, pk, dk, ek;
        logic pen;
        lat = 0; en_cyc = 0; np = 0; k0 = '0; k1 = '0; pk = '0; pen = 1'b0; last_stale = 1'b0;
        move_req = 1'b1; move_dir = d; move_x = x; move_y = y;
        @(posedge clock);
        @(negedge clock);
        move_req = 1'b0;
        check("busy_accept", 32'(busy), 1);
        for (int n = 1; n <= 300; n++) begin
            k = {erase, dir_sel, draw_x, draw_y};
            if (draw_en) begin
                en_cyc++;
                if (!pen || k != pk) begin
                    last_stale = last_stale | done_print;
                    if (np == 0) k0 = k;
                    else k1 = k;
                    np++;
                end
            end
            pen = draw_en;
            pk = k;
            if (move_ack) begin
                lat = n;
                break;
            end
            if (!busy) break;
            move_req = (n == glitch);
            if (n == glitch) {move_dir, move_x, move_y} = {2'd0, 8'd1, 7'd1};
            @(negedge clock);
        end
        move_req = 1'b0;
        dk = {1'b0, d, ex, ey};
        ek = {1'b1, md, mx, my};
        check("latency", lat, es ? 2 : 2 + NPASS * (1 + PASS));
        check("passes", np, es ? 0 : NPASS);
        check("en_cycles", en_cyc, es ? 0 : NPASS * (1 + PASS));
        check("pass0_key", 32'(k0), es ? 0 : 32'(NPASS == 2 ? ek : dk));
        check("pass1_key", 32'(k1), (es || NPASS != 2) ? 0 : 32'(dk));
        {md, mx, my} = {d, ex, ey};
        @(negedge clock);
        check("ack_pulse", 32'(move_ack), 0);
        check("busy_done", 32'(busy), 0);
        check("pos_x", 32'(draw_x), 32'(mx));
        check("pos_y", 32'(draw_y), 32'(my));
        check("pos_dir", 32'(dir_sel), 32'(md));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] rd;
        logic [7:0] rx, ex;
        logic [6:0] ry, ey;
        int h_en, h_ack;
        tbl[0] = '{2'd0, 8'd20, 7'd30, 8'd20, 7'd30, 1'b0};
        tbl[1] = '{2'd1, 8'd200, 7'd127, 8'd155, 7'd115, 1'b0};
        tbl[2] = '{2'd1, 8'd200, 7'd127, 8'd155, 7'd115, 1'b1};
        tbl[3] = '{2'd2, 8'd155, 7'd115, 8'd155, 7'd115, 1'b0};
        tbl[4] = '{2'd2, 8'd156, 7'd116, 8'd155, 7'd115, 1'b1};
        tbl[5] = '{2'd3, 8'd0, 7'd0, 8'd0, 7'd0, 1'b0};
        tbl[6] = '{2'd3, 8'd255, 7'd0, 8'd155, 7'd0, 1'b0};
        tbl[7] = '{2'd3, 8'd154, 7'd114, 8'd154, 7'd114, 1'b0};
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("tbl%0d", i);
            do_check(tbl[i].d, tbl[i].x, tbl[i].y, tbl[i].ex, tbl[i].ey, tbl[i].es, 0);
        end
        tag = "stale_done";
        do_check(2'd0, 8'd40, 7'd40, 8'd40, 7'd40, 1'b0, 0);
        check("stale_seen_in_arm", 32'(last_stale), 1);
        tag = "busy_req";
        do_check(2'd1, 8'd60, 7'd70, 8'd60, 7'd70, 1'b0, GLITCH);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("no_queued_ack", 32'(move_ack), 0);
        end
        tag = "busy_req_again";
        do_check(2'd1, 8'd60, 7'd70, 8'd60, 7'd70, 1'b1, 0);
        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("rnd%0d", i);
            if ($urandom_range(0, 3) == 0) begin
                rd = md; rx = mx; ry = my;
            end else begin
                rd = 2'($urandom_range(0, 3));
                rx = 8'($urandom_range(0, 255));
                ry = 7'($urandom_range(0, 127));
            end
            ex = rx > 8'd155 ? 8'd155 : rx;
            ey = ry > 7'd115 ? 7'd115 : ry;
            do_check(rd, rx, ry, ex, ey, ex == mx && ey == my && rd == md, 0);
        end
        tag = "hang";
        hang = 1'b1;
        h_en = 0; h_ack = 0;
        move_req = 1'b1;
        {move_dir, move_x, move_y} = {md + 2'd1, mx ^ 8'd1, my};
        @(posedge clock);
        @(negedge clock);
        move_req = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (draw_en) h_en++;
            if (move_ack) h_ack++;
            if (!busy) break;
            @(negedge clock);
        end
        check("abort_en_cycles", h_en, 64);
        check("abort_no_ack", h_ack, 0);
        check("abort_err", 32'(err_timeout), 1);
        check("abort_en_low", 32'(draw_en), 0);
        check("abort_x", 32'(draw_x), 32'(mx));
        check("abort_y", 32'(draw_y), 32'(my));
        check("abort_dir", 32'(dir_sel), 32'(md));
        hang = 1'b0;
        tag = "hang_retry_same";
        do_check(md, mx, my, mx, my, 1'b1, 0);
        check("err_sticky", 32'(err_timeout), 1);
        tag = "reset_mid";
        move_req = 1'b1;
        {move_dir, move_x, move_y} = {2'd2, 8'd10, 7'd10};
        @(posedge clock);
        @(negedge clock);
        move_req = 1'b0;
        repeat (20) @(negedge clock);
        check("mid_pass_en", 32'(draw_en), 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        {md, mx, my} = {2'd3, 8'd78, 7'd58};
        tag = "after_reset";
        do_check(2'd0, 8'd20, 7'd30, 8'd20, 7'd30, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
